// File: rtl/led_sequencer_p_if.sv
// Control and observation bundle for the LED sequencer: run/mode/divider
// controls in, LED bank and debug strobes out.
interface led_sequencer_p_if #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 16,
    parameter int LED_W = 8
);
    logic             enable;
    logic [1:0]       mode;
    logic             div_load;
    logic [DIV_W-1:0] div_value;
    logic [LED_W-1:0] leds;
    logic [CNT_W-1:0] counter_out;
    logic [1:0]       state_out;
    logic             tick;
    logic             wrap;

    modport master (
        output enable, mode, div_load, div_value,
        input  leds, counter_out, state_out, tick, wrap
    );

    modport slave (
        input  enable, mode, div_load, div_value,
        output leds, counter_out, state_out, tick, wrap
    );
endinterface

// File: rtl/led_sequencer_p.sv
// LED pattern sequencer: reloadable tick divider, up/down/bounce/hold counter
// and a threshold-driven 4-state FSM whose state is shown as a thermometer.
module led_sequencer_p #(
    parameter int CNT_W      = 8,
    parameter int DIV_W      = 16,
    parameter int LED_W      = 8,
    parameter int TH_COUNT   = 50,
    parameter int TH_DISPLAY = 150,
    parameter int TH_RESET   = 200,
    parameter int TH_IDLE    = 250
) (
    input logic                 clk,
    input logic                 reset,
    led_sequencer_p_if.slave    bus
);
    localparam int PAT_W = LED_W / 2;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [CNT_W-1:0] TH_COUNT_C   = CNT_W'(TH_COUNT);
    localparam logic [CNT_W-1:0] TH_DISPLAY_C = CNT_W'(TH_DISPLAY);
    localparam logic [CNT_W-1:0] TH_RESET_C   = CNT_W'(TH_RESET);
    localparam logic [CNT_W-1:0] TH_IDLE_C    = CNT_W'(TH_IDLE);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT    = 2'd1,
        DISPLAY  = 2'd2,
        RESET_ST = 2'd3
    } state_t;

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_limit_reg;
    logic [CNT_W-1:0] counter_reg;
    logic [CNT_W-1:0] counter_next;
    logic             dir_up_reg;
    logic             dir_up_next;
    logic             wrap_reg;
    logic             wrap_next;
    state_t           state_reg;
    logic [LED_W-1:0] leds_reg;
    logic [CNT_W-1:0] counter_out_reg;
    logic [1:0]       state_out_reg;
    logic             tick_int;
    logic [PAT_W-1:0] pattern;
    int               fill_len;

    // A load cycle restarts the divider, so it suppresses the tick.
    assign tick_int = bus.enable & ~bus.div_load & (div_cnt_reg == div_limit_reg);

    always_comb begin
        counter_next = counter_reg;
        dir_up_next  = dir_up_reg;
        wrap_next    = 1'b0;
        if (tick_int) begin
            case (bus.mode)
                2'b00: begin
                    dir_up_next  = 1'b1;
                    counter_next = counter_reg + CNT_ONE;
                    wrap_next    = (counter_reg == CNT_MAX);
                end
                2'b01: begin
                    counter_next = counter_reg - CNT_ONE;
                    wrap_next    = (counter_reg == CNT_ZERO);
                end
                2'b10: begin
                    // Reversal skips the end value so each extreme is shown once.
                    if (dir_up_reg) begin
                        if (counter_reg == CNT_MAX) begin
                            dir_up_next  = 1'b0;
                            counter_next = CNT_MAX - CNT_ONE;
                            wrap_next    = 1'b1;
                        end else begin
                            counter_next = counter_reg + CNT_ONE;
                        end
                    end else begin
                        if (counter_reg == CNT_ZERO) begin
                            dir_up_next  = 1'b1;
                            counter_next = CNT_ONE;
                            wrap_next    = 1'b1;
                        end else begin
                            counter_next = counter_reg - CNT_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign fill_len = (32'(state_reg) + 1) * (PAT_W / 4);

    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_pattern
            assign pattern[gi] = (gi < fill_len);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_reg     <= '0;
            div_limit_reg   <= '1;
            counter_reg     <= '0;
            dir_up_reg      <= 1'b1;
            wrap_reg        <= 1'b0;
            state_reg       <= IDLE;
            leds_reg        <= '0;
            counter_out_reg <= '0;
            state_out_reg   <= 2'd0;
        end else begin
            if (bus.div_load) begin
                div_limit_reg <= bus.div_value;
                div_cnt_reg   <= '0;
            end else if (tick_int) begin
                div_cnt_reg <= '0;
            end else if (bus.enable) begin
                div_cnt_reg <= div_cnt_reg + DIV_ONE;
            end

            counter_reg <= counter_next;
            dir_up_reg  <= dir_up_next;
            wrap_reg    <= wrap_next;

            if (bus.enable) begin
                if (wrap_reg) begin
                    state_reg <= IDLE;
                end else begin
                    case (state_reg)
                        IDLE:     if (counter_reg > TH_COUNT_C)   state_reg <= COUNT;
                        COUNT:    if (counter_reg > TH_DISPLAY_C) state_reg <= DISPLAY;
                        DISPLAY:  if (counter_reg > TH_RESET_C)   state_reg <= RESET_ST;
                        RESET_ST: if (counter_reg > TH_IDLE_C)    state_reg <= IDLE;
                        default:                                  state_reg <= IDLE;
                    endcase
                end
            end

            // Display copies keep refreshing even while the core is frozen.
            leds_reg        <= {pattern, counter_reg[PAT_W-1:0]};
            counter_out_reg <= counter_reg;
            state_out_reg   <= state_reg;
        end
    end

    assign bus.tick        = tick_int;
    assign bus.wrap        = wrap_reg;
    assign bus.leds        = leds_reg;
    assign bus.counter_out = counter_out_reg;
    assign bus.state_out   = state_out_reg;

endmodule

// File: tb/tb_led_sequencer_p.sv
// Scoreboard bench for led_sequencer_p: a cycle model queues expected outputs
// as stimulus is applied; they are popped and compared once the DUT clocks.
module tb_led_sequencer_p;
    localparam int CNT_W = 8;
    localparam int DIV_W = 4;
    localparam int LED_W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    led_sequencer_p_if #(.CNT_W(CNT_W), .DIV_W(DIV_W), .LED_W(LED_W)) bus ();

    led_sequencer_p #(.CNT_W(CNT_W), .DIV_W(DIV_W), .LED_W(LED_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] leds;
        logic [7:0] cout;
        logic [1:0] sout;
        logic       wrap;
    } exp_t;

    exp_t sb_q[$];
    bit   tick_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    int         m_dcnt, m_lim, m_cnt, m_state;
    bit         m_up, m_wrap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
        end
    endtask

    function automatic logic [3:0] pat(input int s);
        case (s)
            0:       return 4'b0001;
            1:       return 4'b0011;
            2:       return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic model_reset();
        m_dcnt  = 0;
        m_lim   = 15;
        m_cnt   = 0;
        m_up    = 1'b1;
        m_state = 0;
        m_wrap  = 1'b0;
    endtask

    // One clock cycle: inputs were set at the preceding negedge.
    task automatic cycle();
        bit   t;
        bit   nu, nw;
        int   nc, ns;
        exp_t e;
        exp_t got_e;
        #1;
        if (reset) begin
            model_reset();
            t = 1'b0;
        end else begin
            t = bus.enable && !bus.div_load && (m_dcnt == m_lim);
        end
        tick_q.push_back(t);
        check_eq("tick", {31'd0, bus.tick}, {31'd0, tick_q.pop_front()});

        if (reset) begin
            e = '{8'h00, 8'h00, 2'd0, 1'b0};
        end else begin
            e.leds = {pat(m_state), 4'(m_cnt % 16)};
            e.cout = 8'(m_cnt);
            e.sout = 2'(m_state);
            nc = m_cnt;
            nu = m_up;
            nw = 1'b0;
            if (t) begin
                case (bus.mode)
                    2'd0: begin nu = 1'b1; nc = (m_cnt + 1) % 256; nw = (m_cnt == 255); end
                    2'd1: begin nc = (m_cnt + 255) % 256; nw = (m_cnt == 0); end
                    2'd2: begin
                        if (m_up) begin
                            if (m_cnt == 255) begin nu = 1'b0; nc = 254; nw = 1'b1; end
                            else nc = m_cnt + 1;
                        end else begin
                            if (m_cnt == 0) begin nu = 1'b1; nc = 1; nw = 1'b1; end
                            else nc = m_cnt - 1;
                        end
                    end
                    default: ;
                endcase
            end
            ns = m_state;
            if (bus.enable) begin
                if (m_wrap) ns = 0;
                else if (m_state == 0 && m_cnt > 50)  ns = 1;
                else if (m_state == 1 && m_cnt > 150) ns = 2;
                else if (m_state == 2 && m_cnt > 200) ns = 3;
                else if (m_state == 3 && m_cnt > 250) ns = 0;
            end
            if (bus.div_load) begin
                m_lim  = int'(bus.div_value);
                m_dcnt = 0;
            end else if (t) begin
                m_dcnt = 0;
            end else if (bus.enable) begin
                m_dcnt = m_dcnt + 1;
            end
            m_cnt   = nc;
            m_up    = nu;
            m_wrap  = nw;
            m_state = ns;
            e.wrap  = nw;
        end
        sb_q.push_back(e);

        @(posedge clk);
        @(negedge clk);
        cyc++;
        got_e = sb_q.pop_front();
        check_eq("leds",        {24'd0, bus.leds},        {24'd0, got_e.leds});
        check_eq("counter_out", {24'd0, bus.counter_out}, {24'd0, got_e.cout});
        check_eq("state_out",   {30'd0, bus.state_out},   {30'd0, got_e.sout});
        check_eq("wrap",        {31'd0, bus.wrap},        {31'd0, got_e.wrap});
        $display("cyc %0d rst=%0b en=%0b mode=%0d ld=%0b tick=%0b leds=%02h cnt=%0d st=%0d wrap=%0b",
                 cyc, reset, bus.enable, bus.mode, bus.div_load, t,
                 bus.leds, bus.counter_out, bus.state_out, bus.wrap);
    endtask

    initial begin
        bus.enable    = 1'b1;
        bus.mode      = 2'd0;
        bus.div_load  = 1'b0;
        bus.div_value = '0;
        model_reset();

        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;

        // Default period 16 after reset, up mode
        repeat (40) cycle();

        // Fastest tick, run through thresholds and the 255->0 wrap
        bus.div_load  = 1'b1;
        bus.div_value = 4'd0;
        cycle();
        bus.div_load = 1'b0;
        repeat (300) cycle();

        // Bounce starting from 255
        for (int i = 0; i < 300 && m_cnt != 255; i++) cycle();
        bus.mode = 2'd2;
        repeat (520) cycle();

        bus.mode = 2'd3;
        repeat (10) cycle();

        // Down mode from 0: immediate wrap to 255
        bus.mode = 2'd0;
        for (int i = 0; i < 300 && m_cnt != 0; i++) cycle();
        bus.mode = 2'd1;
        repeat (10) cycle();

        // Freeze with a divider reload during the pause
        bus.mode      = 2'd0;
        bus.div_load  = 1'b1;
        bus.div_value = 4'd3;
        cycle();
        bus.div_load = 1'b0;
        repeat (13) cycle();
        bus.enable = 1'b0;
        repeat (8) cycle();
        bus.div_load  = 1'b1;
        bus.div_value = 4'd5;
        cycle();
        bus.div_load = 1'b0;
        repeat (11) cycle();
        bus.enable = 1'b1;
        repeat (30) cycle();

        // Reach DISPLAY, then assert reset between clock edges
        bus.div_load  = 1'b1;
        bus.div_value = 4'd0;
        cycle();
        bus.div_load = 1'b0;
        for (int i = 0; i < 600 && m_state != 2; i++) cycle();
        cycle();
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_leds",  {24'd0, bus.leds},        32'd0);
        check_eq("async_cnt",   {24'd0, bus.counter_out}, 32'd0);
        check_eq("async_state", {30'd0, bus.state_out},   32'd0);
        check_eq("async_wrap",  {31'd0, bus.wrap},        32'd0);
        check_eq("async_tick",  {31'd0, bus.tick},        32'd0);
        model_reset();
        cycle();
        reset = 1'b0;
        repeat (40) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
